maze_player_ctrl: RTL and testbench
===================================

// Module: maze_player_ctrl
// PURPOSE
// - Sequences player movement for the VGA maze; sits beside vga_sync/vga_frame under vga_maze_top.
// - Once every MOVE_DIV frames, samples direction buttons, reads the target tile from the shared maze ROM via req/ack, and commits the move if the tile is open.
// - Publishes the player tile position and a win flag to vga_frame for drawing.
// - All position updates fall in vertical blanking, so active video always sees a stable position.
// PARAMETERS
// - COLS       40  maze width in tiles (640/16)
// - ROWS       30  maze height in tiles (480/16)
// - START_COL   1  player column after reset
// - START_ROW   1  player row after reset
// - EXIT_COL   38  exit tile column
// - EXIT_ROW   28  exit tile row
// - MOVE_DIV    8  frames per move attempt; must be >= 1
// - Derived widths: CW=$clog2(COLS), RW=$clog2(ROWS), AW=$clog2(COLS*ROWS)
// PORTS
// - clk           in   1   pixel clock
// - rst           in   1   asynchronous reset, active-high
// - i_frame_start in   1   one-cycle pulse at start of vblank, from vga_sync
// - i_up          in   1   button level, already synchronized and debounced
// - i_down        in   1   button level, already synchronized and debounced
// - i_left        in   1   button level, already synchronized and debounced
// - i_right       in   1   button level, already synchronized and debounced
// - o_rom_req     out  1   maze ROM read request
// - o_rom_addr    out  AW  tile address = row*COLS + col
// - i_rom_ack     in   1   grant/data-valid strobe from ROM arbiter
// - i_rom_wall    in   1   tile is a wall; valid only when i_rom_ack=1
// - o_player_col  out  CW  current player column
// - o_player_row  out  RW  current player row
// - o_win         out  1   player is on the exit tile (sticky)
// - o_busy        out  1   high in any state other than IDLE or DONE
// BEHAVIOUR
// - Reset values:
//   - o_player_col=START_COL, o_player_row=START_ROW.
//   - o_rom_req=0, o_rom_addr=0, o_win=0, o_busy=0.
//   - Frame counter=0; FSM state=IDLE.
// - Frame counter:
//   - Increments on every i_frame_start, in every state except DONE; wraps from MOVE_DIV-1 to 0.
//   - tick = i_frame_start && cnt==MOVE_DIV-1.
//   - A tick seen outside IDLE is dropped, not queued.
// - FSM:
//   - IDLE -> SAMPLE on tick.
//   - SAMPLE (1 cycle): choose a direction, priority up > down > left > right. Up=row-1, down=row+1, left=col-1, right=col+1.
//     - No button held -> IDLE.
//     - Target off-grid (see CONFIGURATION) -> IDLE with no ROM access.
//     - Otherwise latch target col/row and address, then -> REQ.
//   - REQ: o_rom_req=1, o_rom_addr held stable until ack.
//     - i_rom_ack may arrive in the first REQ cycle or any later cycle.
//     - On ack: deassert req the next cycle.
//     - i_rom_wall=1 -> IDLE, position unchanged.
//     - i_rom_wall=0 -> register target into position, then -> CHECK.
//   - CHECK (1 cycle): position==(EXIT_COL,EXIT_ROW) -> DONE with o_win=1; else -> IDLE.
//   - DONE: absorbing until rst. No requests; position frozen.
// - Latency: tick to o_rom_req is 1 cycle; ack to new position visible is 1 cycle.
// - Button changes after SAMPLE have no effect on the move in flight.
// - Address arithmetic is done at AW bits; no truncation for legal tiles.
// - Reset asserted mid-REQ: o_rom_req drops asynchronously. A late ack with no request outstanding is ignored.
// CONFIGURATION
// - Macro MAZE_WRAP_EN.
// - Defined: moves off an edge wrap around (col 0 left -> COLS-1, row ROWS-1 down -> 0). The wrapped tile is still wall-checked through the ROM.
// - Undefined: any off-grid target is rejected in SAMPLE, no ROM request is issued, and state returns to IDLE.
// TESTING
// - Reset, no buttons, 20 frame pulses -> position stays (1,1); o_rom_req never asserts; o_win=0.
// - i_right held, ack after 3 cycles with wall=0 -> req asserts 1 cycle after the 8th frame pulse; addr=1*40+2=42; col=2 the cycle after ack.
// - i_up and i_left held, tile open -> up wins: addr=0*40+1=1, row=0. Next move attempt up from row 0:
//   - without MAZE_WRAP_EN: no req issued.
//   - with MAZE_WRAP_EN: addr=29*40+1=1161.
// - Wall returned (wall=1 with ack) -> position unchanged; next tick tries again; a frame pulse during REQ is dropped without a queued extra move.
// - Player at (37,28), i_right, open tile -> position (38,28), o_win=1 after CHECK. Later ticks issue no req; o_win stays 1 until rst.
// - rst pulsed while REQ is waiting for ack -> req=0 immediately, position back at (1,1); an ack 2 cycles later has no effect.

Source files
------------

// File: rtl/maze_player_ctrl.sv
// maze_player_ctrl: frame-paced player movement with ROM wall check and win detection.
// Optional feature: define MAZE_WRAP_EN to wrap moves across the grid edges.
module maze_player_ctrl #(
  parameter int COLS      = 40,
  parameter int ROWS      = 30,
  parameter int START_COL = 1,
  parameter int START_ROW = 1,
  parameter int EXIT_COL  = 38,
  parameter int EXIT_ROW  = 28,
  parameter int MOVE_DIV  = 8,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int AW = $clog2(COLS*ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_frame_start,
  input  logic          i_up,
  input  logic          i_down,
  input  logic          i_left,
  input  logic          i_right,
  output logic          o_rom_req,
  output logic [AW-1:0] o_rom_addr,
  input  logic          i_rom_ack,
  input  logic          i_rom_wall,
  output logic [CW-1:0] o_player_col,
  output logic [RW-1:0] o_player_row,
  output logic          o_win,
  output logic          o_busy
);
  localparam int NW = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;
  localparam logic [NW-1:0] CNT_MAX   = NW'(MOVE_DIV-1);
  localparam logic [CW-1:0] COL_MAX   = CW'(COLS-1);
  localparam logic [CW-1:0] COL_START = CW'(START_COL);
  localparam logic [CW-1:0] COL_EXIT  = CW'(EXIT_COL);
  localparam logic [RW-1:0] ROW_MAX   = RW'(ROWS-1);
  localparam logic [RW-1:0] ROW_START = RW'(START_ROW);
  localparam logic [RW-1:0] ROW_EXIT  = RW'(EXIT_ROW);
  typedef enum logic [2:0] {IDLE, SAMPLE, REQ, CHECK, DONE} state_t;
  state_t state_q, state_d;
  logic [NW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] col_q, col_d, tcol_q, tcol_d, ncol;
  logic [RW-1:0] row_q, row_d, trow_q, trow_d, nrow;
  logic [AW-1:0] addr_q, addr_d, naddr;
  logic win_q, win_d, tick, any_btn, off_grid, reject;
  assign any_btn = i_up | i_down | i_left | i_right;
  assign tick    = i_frame_start && cnt_q == CNT_MAX;
  // Candidate target; off_grid also selects the wrapped coordinate.
  always_comb begin
    ncol     = col_q;
    nrow     = row_q;
    off_grid = 1'b0;
    if (i_up) begin
      off_grid = row_q == '0;
      nrow     = off_grid ? ROW_MAX : row_q - RW'(1);
    end else if (i_down) begin
      off_grid = row_q == ROW_MAX;
      nrow     = off_grid ? '0 : row_q + RW'(1);
    end else if (i_left) begin
      off_grid = col_q == '0;
      ncol     = off_grid ? COL_MAX : col_q - CW'(1);
    end else if (i_right) begin
      off_grid = col_q == COL_MAX;
      ncol     = off_grid ? '0 : col_q + CW'(1);
    end
    naddr = AW'(nrow) * AW'(COLS) + AW'(ncol);
  end
`ifdef MAZE_WRAP_EN
  assign reject = !any_btn;
`else
  assign reject = !any_btn || off_grid;
`endif
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    tcol_d  = tcol_q;
    trow_d  = trow_q;
    addr_d  = addr_q;
    win_d   = win_q;
    cnt_d   = (i_frame_start && state_q != DONE) ? (cnt_q == CNT_MAX ? '0 : cnt_q + NW'(1)) : cnt_q;
    case (state_q)
      IDLE:   state_d = tick ? SAMPLE : IDLE;
      SAMPLE: begin
        state_d = reject ? IDLE : REQ;
        if (!reject) begin
          tcol_d = ncol;
          trow_d = nrow;
          addr_d = naddr;
        end
      end
      REQ: if (i_rom_ack) begin
        state_d = i_rom_wall ? IDLE : CHECK;
        col_d   = i_rom_wall ? col_q : tcol_q;
        row_d   = i_rom_wall ? row_q : trow_q;
      end
      CHECK: begin
        win_d   = col_q == COL_EXIT && row_q == ROW_EXIT;
        state_d = win_d ? DONE : IDLE;
      end
      default: state_d = DONE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      col_q   <= COL_START;
      row_q   <= ROW_START;
      tcol_q  <= COL_START;
      trow_q  <= ROW_START;
      addr_q  <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      tcol_q  <= tcol_d;
      trow_q  <= trow_d;
      addr_q  <= addr_d;
      win_q   <= win_d;
    end
  end
  assign o_rom_req    = state_q == REQ;
  assign o_rom_addr   = addr_q;
  assign o_player_col = col_q;
  assign o_player_row = row_q;
  assign o_win        = win_q;
  assign o_busy       = state_q != IDLE && state_q != DONE;
endmodule

// File: tb/tb_maze_player_ctrl.sv
// tb_maze_player_ctrl: scoreboard bench; stimulus queues expected ROM addresses and moves, a monitor checks them.
module tb_maze_player_ctrl;
  localparam int CW = 6, RW = 5, AW = 11;
  logic clk = 0, rst = 1, i_frame_start = 0;
  logic i_up = 0, i_down = 0, i_left = 0, i_right = 0;
  logic o_rom_req, i_rom_ack, i_rom_wall, o_win, o_busy;
  logic [AW-1:0] o_rom_addr;
  logic [CW-1:0] o_player_col;
  logic [RW-1:0] o_player_row;
  logic resp_ack = 0, resp_wall = 0, man_ack = 0, man_wall = 0;
  logic resp_en = 1, wall_cfg = 0;
  int ack_dly = 1, ack_n = 0;
  int errors = 0, checks = 0;
  int exp_addr[$], exp_pos[$];
  assign i_rom_ack  = resp_ack | man_ack;
  assign i_rom_wall = man_ack ? man_wall : resp_wall;
  maze_player_ctrl dut (
    .clk(clk), .rst(rst), .i_frame_start(i_frame_start),
    .i_up(i_up), .i_down(i_down), .i_left(i_left), .i_right(i_right),
    .o_rom_req(o_rom_req), .o_rom_addr(o_rom_addr),
    .i_rom_ack(i_rom_ack), .i_rom_wall(i_rom_wall),
    .o_player_col(o_player_col), .o_player_row(o_player_row),
    .o_win(o_win), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask
  task automatic frame();
    i_frame_start = 1;
    cyc();
    i_frame_start = 0;
    cyc();
  endtask
  task automatic do_reset();
    rst = 1;
    cyc();
    rst = 0;
    cyc();
  endtask
  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 60) begin
      cyc();
      n++;
    end
    chk("idle_timeout", int'(o_busy), 0);
  endtask
  task automatic set_btn(input logic u, input logic d, input logic l, input logic r);
    i_up = u; i_down = d; i_left = l; i_right = r;
  endtask
  task automatic chk_pos(input string name, input int c, input int r);
    chk(name, int'(o_player_col) * 256 + int'(o_player_row), c * 256 + r);
  endtask
  // One move attempt: buttons held across exactly MOVE_DIV frames.
  task automatic move(input logic u, input logic d, input logic l, input logic r,
                      input bit req, input int a, input bit mv, input int c, input int rw);
    set_btn(u, d, l, r);
    if (req) exp_addr.push_back(a);
    if (mv) exp_pos.push_back(c * 256 + rw);
    repeat (8) frame();
    wait_idle();
    set_btn(0, 0, 0, 0);
  endtask
  // ROM responder: acks after ack_dly cycles of outstanding request.
  always begin
    @(posedge clk);
    #3;
    if (!resp_en || rst) begin
      resp_ack = 0;
      ack_n = 0;
    end else if (resp_ack) resp_ack = 0;
    else if (o_rom_req) begin
      ack_n++;
      if (ack_n >= ack_dly) begin
        resp_ack  = 1;
        resp_wall = wall_cfg;
        ack_n     = 0;
      end
    end
  end
  // Monitor: pops expectations on each new request and each position change.
  logic prev_req = 0;
  logic [AW-1:0] prev_addr = '0;
  logic [CW-1:0] prev_col = 1;
  logic [RW-1:0] prev_row = 1;
  always begin
    @(posedge clk);
    #1;
    if (!rst) begin
      if (o_rom_req && !prev_req) begin
        if (exp_addr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: addr=%0d, none expected at %0t", o_rom_addr, $time);
        end else chk("req_addr", int'(o_rom_addr), exp_addr.pop_front());
      end else if (o_rom_req) chk("addr_stable", int'(o_rom_addr), int'(prev_addr));
      if (o_player_col != prev_col || o_player_row != prev_row) begin
        if (exp_pos.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_move: pos=(%0d,%0d), none expected at %0t", o_player_col, o_player_row, $time);
        end else chk("move_pos", int'(o_player_col) * 256 + int'(o_player_row), exp_pos.pop_front());
        chk("move_on_ack", int'(i_rom_ack), 1);
      end
    end
    prev_req  = rst ? 1'b0 : o_rom_req;
    prev_addr = o_rom_addr;
    prev_col  = o_player_col;
    prev_row  = o_player_row;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    cyc();
    chk("rst_req", int'(o_rom_req), 0);
    chk("rst_addr", int'(o_rom_addr), 0);
    chk("rst_win", int'(o_win), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk_pos("rst_pos", 1, 1);
    rst = 0;
    cyc();
    // No buttons across 20 frames: no requests, no movement.
    repeat (20) frame();
    cyc();
    chk_pos("idle_pos", 1, 1);
    chk("idle_win", int'(o_win), 0);
    // Right move, ack after 3 cycles; request one cycle after the tick edge.
    do_reset();
    ack_dly = 3;
    set_btn(0, 0, 0, 1);
    exp_addr.push_back(42);
    exp_pos.push_back(2 * 256 + 1);
    repeat (7) frame();
    chk("no_req_before_tick", int'(o_rom_req), 0);
    i_frame_start = 1;
    cyc();
    i_frame_start = 0;
    chk("req_in_sample", int'(o_rom_req), 0);
    cyc();
    chk("req_latency", int'(o_rom_req), 1);
    wait_idle();
    set_btn(0, 0, 0, 0);
    chk_pos("right_pos", 2, 1);
    // Up beats left; then up again from row 0.
    do_reset();
    ack_dly = 1;
    move(1, 0, 1, 0, 1, 1, 1, 1, 0);
    chk_pos("up_pos", 1, 0);
`ifdef MAZE_WRAP_EN
    move(1, 0, 0, 0, 1, 1161, 1, 1, 29);
    chk_pos("wrap_pos", 1, 29);
`else
    move(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_pos("edge_pos", 1, 0);
`endif
    // Wall blocks the move; retry succeeds; a tick during REQ is dropped.
    do_reset();
    wall_cfg = 1;
    move(0, 0, 0, 1, 1, 42, 0, 0, 0);
    chk_pos("wall_pos", 1, 1);
    wall_cfg = 0;
    ack_dly = 20;
    set_btn(0, 0, 0, 1);
    exp_addr.push_back(42);
    exp_pos.push_back(2 * 256 + 1);
    repeat (8) frame();
    chk("req_held", int'(o_rom_req), 1);
    repeat (8) frame();
    chk("req_still_held", int'(o_rom_req), 1);
    wait_idle();
    repeat (10) cyc();
    set_btn(0, 0, 0, 0);
    chk_pos("retry_pos", 2, 1);
    // Walk to the exit: down to row 28, then right to column 38.
    do_reset();
    ack_dly = 1;
    for (int r = 2; r <= 28; r++) move(0, 1, 0, 0, 1, r * 40 + 1, 1, 1, r);
    for (int c = 2; c <= 37; c++) move(0, 0, 0, 1, 1, 28 * 40 + c, 1, c, 28);
    chk("win_before_exit", int'(o_win), 0);
    move(0, 0, 0, 1, 1, 28 * 40 + 38, 1, 38, 28);
    chk("win_set", int'(o_win), 1);
    chk("done_busy", int'(o_busy), 0);
    set_btn(0, 0, 0, 1);
    repeat (16) frame();
    set_btn(0, 0, 0, 0);
    chk("win_sticky", int'(o_win), 1);
    chk_pos("done_pos", 38, 28);
    // Reset while waiting for ack; a late ack is ignored.
    do_reset();
    chk("win_cleared", int'(o_win), 0);
    resp_en = 0;
    set_btn(0, 0, 0, 1);
    exp_addr.push_back(42);
    repeat (8) frame();
    chk("req_waiting", int'(o_rom_req), 1);
    #1;
    rst = 1;
    #1;
    chk("req_async_drop", int'(o_rom_req), 0);
    chk_pos("rst_mid_pos", 1, 1);
    cyc();
    rst = 0;
    set_btn(0, 0, 0, 0);
    cyc();
    man_ack = 1;
    man_wall = 0;
    cyc();
    man_ack = 0;
    cyc();
    chk("late_ack_req", int'(o_rom_req), 0);
    chk_pos("late_ack_pos", 1, 1);
    chk("addr_queue_empty", exp_addr.size(), 0);
    chk("pos_queue_empty", exp_pos.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
